// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//
// Walks a song held in an external synchronous ROM (one-cycle read latency)
// and drives the square-wave generator. Each ROM word is {freq[15:0], dur[7:0]}:
// dur == 0 marks the end of the song; freq == 0 with dur > 0 is a rest.
// Every note lasts dur ticks, and the last GAP_TICKS ticks of a note are
// silenced as an articulation gap when the note is long enough to have one.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     single-cycle start request (only honoured in IDLE)
//   stop      single-cycle stop request (highest priority, any state)
//   loop      level; restart at the end marker instead of finishing
//   rom_addr  registered ROM address
//   rom_data  ROM word, valid one cycle after rom_addr
//   freq      frequency to the tone generator, 0 = silence
//   playing   high while a song is active (FETCH, LOAD, PLAY)
//   done      one-cycle pulse when a song ends in non-loop mode
// -----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int TICK_HZ   = 100,
    parameter int GAP_TICKS = 1,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [15:0]       freq,
    output logic              playing,
    output logic              done
);

    localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
    localparam int PRESC_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [7:0]         GAP_T     = 8'(GAP_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [15:0]         freq_reg, freq_next;
    logic [7:0]          remaining_reg, remaining_next;
    logic [PRESC_W-1:0]  presc_reg, presc_next;
    logic                gap_en_reg, gap_en_next;
    logic                done_reg, done_next;
    // start is registered once before the FSM sees it, which gives the
    // documented start-to-FETCH latency of two edges. A simultaneous stop
    // cancels it so the pair cannot launch a song one cycle later.
    logic                start_reg;

    logic [15:0] rom_freq;
    logic [7:0]  rom_dur;
    logic [7:0]  rem_dec;
    logic        tick;

    assign rom_freq = rom_data[23:8];
    assign rom_dur  = rom_data[7:0];
    assign rem_dec  = remaining_reg - 8'd1;
    assign tick     = (presc_reg == PRESC_MAX);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            freq_reg      <= '0;
            remaining_reg <= '0;
            presc_reg     <= '0;
            gap_en_reg    <= 1'b0;
            done_reg      <= 1'b0;
            start_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            freq_reg      <= freq_next;
            remaining_reg <= remaining_next;
            presc_reg     <= presc_next;
            gap_en_reg    <= gap_en_next;
            done_reg      <= done_next;
            start_reg     <= start & ~stop;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        freq_next      = freq_reg;
        remaining_next = remaining_reg;
        presc_next     = presc_reg;
        gap_en_next    = gap_en_reg;
        done_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start_reg) begin
                    state_next = S_FETCH;
                end
            end

            // rom_addr has been stable since the previous edge; the ROM
            // presents the word at the end of this cycle.
            S_FETCH: begin
                state_next = S_LOAD;
            end

            S_LOAD: begin
                if (rom_dur == 8'd0) begin
                    // Looping an empty song (marker at address 0) would
                    // refetch forever, so it finishes like a non-loop song.
                    if (loop && (addr_reg != '0)) begin
                        addr_next  = '0;
                        state_next = S_FETCH;
                    end else begin
                        done_next      = 1'b1;
                        addr_next      = '0;
                        freq_next      = '0;
                        remaining_next = '0;
                        presc_next     = '0;
                        gap_en_next    = 1'b0;
                        state_next     = S_IDLE;
                    end
                end else begin
                    remaining_next = rom_dur;
                    presc_next     = '0;
                    freq_next      = rom_freq;
                    // Notes no longer than the gap keep sounding throughout.
                    gap_en_next    = (rom_dur > GAP_T);
                    state_next     = S_PLAY;
                end
            end

            S_PLAY: begin
                if (tick) begin
                    presc_next     = '0;
                    remaining_next = rem_dec;
                    if (rem_dec == 8'd0) begin
                        // freq is left as is: it holds through FETCH/LOAD.
                        addr_next  = addr_reg + ADDR_W'(1);
                        state_next = S_FETCH;
                    end else if (gap_en_reg && (rem_dec <= GAP_T)) begin
                        freq_next = '0;
                    end
                end else begin
                    presc_next = presc_reg + PRESC_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // stop overrides whatever the FSM decided above.
        if (stop) begin
            state_next     = S_IDLE;
            addr_next      = '0;
            freq_next      = '0;
            remaining_next = '0;
            presc_next     = '0;
            gap_en_next    = 1'b0;
            done_next      = 1'b0;
        end
    end

    assign rom_addr = addr_reg;
    assign freq     = freq_reg;
    assign playing  = (state_reg != S_IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//
// Directed bench for melody_sequencer with 10 clock cycles per tick and a
// one-tick gap. Main stimulus is a table of segments: each record gives the
// inputs for its first cycle (start/stop) and the level of loop, a cycle
// count, and the outputs expected after every edge of the segment. A second
// instance with ADDR_W = 2 exercises address wraparound.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

    typedef struct {
        logic        st;
        logic        sp;
        logic        lp;
        int          n;
        logic [15:0] f;
        logic        pl;
        logic        dn;
        logic [7:0]  a;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start, stop, loop;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [15:0] freq;
    logic        playing, done;

    logic        start2, stop2, loop2;
    logic [1:0]  rom_addr2;
    logic [23:0] rom_data2;
    logic [15:0] freq2;
    logic        playing2, done2;

    logic [23:0] rom_mem  [0:255];
    logic [23:0] rom_mem2 [0:3];

    int   vec_count;
    int   miss_count;
    vec_t tbl[$];

    melody_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(1), .ADDR_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .rom_addr(rom_addr), .rom_data(rom_data), .freq(freq),
        .playing(playing), .done(done)
    );

    melody_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(1), .ADDR_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .loop(loop2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .freq(freq2),
        .playing(playing2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous ROM models
    always @(posedge clk) rom_data  <= rom_mem[rom_addr];
    always @(posedge clk) rom_data2 <= rom_mem2[rom_addr2];

    function automatic logic [23:0] word(input int f, input int d);
        return {16'(f), 8'(d)};
    endfunction

    task automatic chk(input string name, input int got, input int exp, output bit bad);
        vec_count++;
        bad = 1'b0;
        if (got != exp) begin
            miss_count++;
            bad = 1'b1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic load_song(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2);
        for (int i = 0; i < 256; i++) rom_mem[i] = 24'd0;
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
    endtask

    task automatic add(input logic st, input logic sp, input logic lp, input int n,
                       input int f, input logic pl, input logic dn, input int a);
        vec_t v;
        v.st = st; v.sp = sp; v.lp = lp; v.n = n;
        v.f = 16'(f); v.pl = pl; v.dn = dn; v.a = 8'(a);
        tbl.push_back(v);
    endtask

    // Apply table records [lo, hi) and compare every cycle.
    task automatic run_range(input string tname, input int lo, input int hi);
        bit b;
        for (int i = lo; i < hi; i++) begin
            int bad_here;
            bad_here = 0;
            for (int c = 0; c < tbl[i].n; c++) begin
                @(negedge clk);
                start = (c == 0) ? tbl[i].st : 1'b0;
                stop  = (c == 0) ? tbl[i].sp : 1'b0;
                loop  = tbl[i].lp;
                @(posedge clk);
                #1;
                chk({tname, ".freq"},    int'(freq),     int'(tbl[i].f),  b); bad_here += int'(b);
                chk({tname, ".playing"}, int'(playing),  int'(tbl[i].pl), b); bad_here += int'(b);
                chk({tname, ".done"},    int'(done),     int'(tbl[i].dn), b); bad_here += int'(b);
                chk({tname, ".addr"},    int'(rom_addr), int'(tbl[i].a),  b); bad_here += int'(b);
            end
            $display("%s seg %0d: st=%0b sp=%0b lp=%0b cycles=%0d freq=%0d playing=%0b done=%0b addr=%0d bad=%0d",
                     tname, i - lo, tbl[i].st, tbl[i].sp, tbl[i].lp, tbl[i].n,
                     tbl[i].f, tbl[i].pl, tbl[i].dn, tbl[i].a, bad_here);
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int t2_lo, t2_hi, t3_hi, t4_hi, t5_hi, t6_hi, r_hi, r2_hi;
        bit b;

        vec_count  = 0;
        miss_count = 0;
        start = 0; stop = 0; loop = 0;
        start2 = 0; stop2 = 0; loop2 = 0;
        for (int i = 0; i < 4; i++) rom_mem2[i] = word(100 * (i + 1), 1);
        load_song(word(440, 3), word(880, 2), word(0, 0));

        // ---------------- table ----------------
        // basic song
        t2_lo = tbl.size();
        add(1,0,0, 1,   0,0,0,0);
        add(0,0,0, 2,   0,1,0,0);
        add(0,0,0, 20,440,1,0,0);
        add(0,0,0, 10,  0,1,0,0);
        add(0,0,0, 2,   0,1,0,1);
        add(0,0,0, 10,880,1,0,1);
        add(0,0,0, 10,  0,1,0,1);
        add(0,0,0, 2,   0,1,0,2);
        add(0,0,0, 1,   0,0,1,0);
        add(0,0,0, 3,   0,0,0,0);
        t2_hi = tbl.size();
        // loop, then loop cleared mid-song
        add(1,0,1, 1,   0,0,0,0);
        add(0,0,1, 2,   0,1,0,0);
        add(0,0,1, 20,440,1,0,0);
        add(0,0,1, 10,  0,1,0,0);
        add(0,0,1, 2,   0,1,0,1);
        add(0,0,1, 10,880,1,0,1);
        add(0,0,1, 10,  0,1,0,1);
        add(0,0,1, 2,   0,1,0,2);
        add(0,0,1, 2,   0,1,0,0);
        add(0,0,0, 20,440,1,0,0);
        add(0,0,0, 10,  0,1,0,0);
        add(0,0,0, 2,   0,1,0,1);
        add(0,0,0, 10,880,1,0,1);
        add(0,0,0, 10,  0,1,0,1);
        add(0,0,0, 2,   0,1,0,2);
        add(0,0,0, 1,   0,0,1,0);
        add(0,0,0, 2,   0,0,0,0);
        t3_hi = tbl.size();
        // rest then short note (no gap, freq held through FETCH/LOAD)
        add(1,0,0, 1,   0,0,0,0);
        add(0,0,0, 2,   0,1,0,0);
        add(0,0,0, 20,  0,1,0,0);
        add(0,0,0, 2,   0,1,0,1);
        add(0,0,0, 10,660,1,0,1);
        add(0,0,0, 2, 660,1,0,2);
        add(0,0,0, 1,   0,0,1,0);
        add(0,0,0, 2,   0,0,0,0);
        t4_hi = tbl.size();
        // stop / start corner cases
        add(1,0,0, 1,   0,0,0,0);
        add(0,0,0, 2,   0,1,0,0);
        add(0,0,0, 5, 440,1,0,0);
        add(1,0,0, 1, 440,1,0,0);
        add(0,0,0, 14,440,1,0,0);
        add(0,0,0, 10,  0,1,0,0);
        add(0,0,0, 2,   0,1,0,1);
        add(0,0,0, 4, 880,1,0,1);
        add(0,1,0, 1,   0,0,0,0);
        add(0,0,0, 3,   0,0,0,0);
        add(1,1,0, 1,   0,0,0,0);
        add(0,0,0, 4,   0,0,0,0);
        t5_hi = tbl.size();
        // empty song with loop set
        add(1,0,1, 1,   0,0,0,0);
        add(0,0,1, 2,   0,1,0,0);
        add(0,0,1, 1,   0,0,1,0);
        add(0,0,1, 3,   0,0,0,0);
        t6_hi = tbl.size();
        // into PLAY, then asynchronous reset
        add(1,0,0, 1,   0,0,0,0);
        add(0,0,0, 2,   0,1,0,0);
        add(0,0,0, 8, 440,1,0,0);
        r_hi = tbl.size();
        add(0,0,0, 4,   0,0,0,0);
        r2_hi = tbl.size();

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        #12;
        chk("reset.freq",    int'(freq),     0, b);
        chk("reset.playing", int'(playing),  0, b);
        chk("reset.done",    int'(done),     0, b);
        chk("reset.addr",    int'(rom_addr), 0, b);
        @(negedge clk);
        rst_n = 1'b1;

        run_range("basic", t2_lo, t2_hi);
        run_range("loop",  t2_hi, t3_hi);
        load_song(word(0, 2), word(660, 1), word(0, 0));
        run_range("rest",  t3_hi, t4_hi);
        load_song(word(440, 3), word(880, 2), word(0, 0));
        run_range("stop",  t4_hi, t5_hi);
        load_song(word(0, 0), word(440, 3), word(0, 0));
        run_range("empty", t5_hi, t6_hi);

        // asynchronous reset mid-note
        load_song(word(440, 3), word(880, 2), word(0, 0));
        run_range("prerst", t6_hi, r_hi);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.freq",    int'(freq),     0, b);
        chk("async_rst.playing", int'(playing),  0, b);
        chk("async_rst.done",    int'(done),     0, b);
        chk("async_rst.addr",    int'(rom_addr), 0, b);
        $display("async reset mid-note: freq=%0d playing=%0b addr=%0d", freq, playing, rom_addr);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_range("postrst", r_hi, r2_hi);

        // address wrap on the 2-bit instance: notes 100,200,300,400 of one tick
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        for (int e = 1; e <= 3 + 12 * 5 + 5; e++) begin
            @(posedge clk);
            #1;
            if (e >= 3 && ((e - 3) % 12) == 5) begin
                int k;
                k = (e - 3) / 12;
                chk("wrap.freq",    int'(freq2),     100 * ((k % 4) + 1), b);
                chk("wrap.addr",    int'(rom_addr2), k % 4, b);
                chk("wrap.playing", int'(playing2),  1, b);
                $display("wrap note %0d: freq=%0d addr=%0d", k, freq2, rom_addr2);
            end
        end
        @(negedge clk);
        stop2 = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap.stop_playing", int'(playing2), 0, b);
        chk("wrap.stop_freq",    int'(freq2),    0, b);
        @(negedge clk);
        stop2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
